// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the default operand width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sub_stage.sv
// Combinational subtractor built as a + ~b + 1; borrow is the inverted
// carry out, so borrow=1 means a < b.
module sub_stage #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic carry_out;

  assign {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign borrow = ~carry_out;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and a divide-by-zero shortcut.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             diff_msb_unused;

  // The extra bit keeps the partial remainder's shifted-out MSB so the
  // trial compare is exact even when R already uses its top bit.
  assign trial = {r_reg, q_reg[WIDTH-1]};

  sub_stage #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a     (trial),
    .b     ({1'b0, d_reg}),
    .diff  (diff),
    .borrow(borrow)
  );

  // After a successful subtract the remainder is below D, so its top bit is zero.
  assign r_next          = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_next          = {q_reg[WIDTH-2:0], ~borrow};
  assign diff_msb_unused = diff[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= '0;
            if (divisor != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed vector table,
// multi-cycle corner sequences and an all-pairs sweep against a reference model.
module tb_seq_divider;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int checks = 0;
  int passes = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               lat;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns at the sample point just after that edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start    = 1'b0;
  endtask

  // Bounded wait for done; lat counts cycles since the accepting edge.
  task automatic waitDone(output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  function automatic void refModel(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q  = (1 << WIDTH) - 1;
      r  = a;
      dz = 1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 0;
    end
  endfunction

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, busy_n, done_n;
    int mq, mr, mdz;

    vecs[0] = '{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1, dz: 1'b0, lat: 5};
    vecs[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, dz: 1'b0, lat: 5};
    vecs[2] = '{a: 4'd2,  b: 4'd9, q: 4'd0,  r: 4'd2, dz: 1'b0, lat: 5};
    vecs[3] = '{a: 4'd7,  b: 4'd0, q: 4'd15, r: 4'd7, dz: 1'b1, lat: 1};
    vecs[4] = '{a: 4'd8,  b: 4'd2, q: 4'd4,  r: 4'd0, dz: 1'b0, lat: 5};
    vecs[5] = '{a: 4'd11, b: 4'd4, q: 4'd2,  r: 4'd3, dz: 1'b0, lat: 5};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    checkOutput("reset_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      waitDone(lat, busy_n);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].lat - 1);
      checkOutput($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      checkOutput($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      checkOutput($sformatf("vec%0d_div_by_zero", i), div_by_zero, vecs[i].dz);
      tick();
      checkOutput($sformatf("vec%0d_done_one_cycle", i), done, 0);
    end

    // Second start with new operands during RUN must be ignored.
    applyStimulus(4'd12, 4'd5);
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    tick(); tick();
    start = 1'b0;
    waitDone(lat, busy_n);
    checkOutput("repulse_done_seen", done, 1);
    checkOutput("repulse_quotient", quotient, 2);
    checkOutput("repulse_remainder", remainder, 2);
    done_n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) done_n++;
    end
    checkOutput("repulse_extra_done", done_n, 0);

    // Reset during iteration 2 aborts immediately with no later done.
    applyStimulus(4'd14, 4'd3);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
    tick();
    rst = 1'b0;
    done_n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done || busy) done_n++;
    end
    checkOutput("abort_no_activity", done_n, 0);
    applyStimulus(4'd14, 4'd3);
    waitDone(lat, busy_n);
    checkOutput("after_abort_latency", lat, 5);
    checkOutput("after_abort_quotient", quotient, 4);
    checkOutput("after_abort_remainder", remainder, 2);
    tick();

    // All operand pairs, random operands presented on the DONE cycle, random gaps.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        refModel(a, b, mq, mr, mdz);
        applyStimulus(a[WIDTH-1:0], b[WIDTH-1:0]);
        waitDone(lat, busy_n);
        checkOutput($sformatf("sweep_%0d_%0d_latency", a, b), lat, (b == 0) ? 1 : 5);
        checkOutput($sformatf("sweep_%0d_%0d_result", a, b), {div_by_zero, quotient, remainder}, {mdz[0], mq[WIDTH-1:0], mr[WIDTH-1:0]});
        if (b != 0) begin
          checkOutput($sformatf("sweep_%0d_%0d_identity", a, b), int'(quotient) * b + int'(remainder), a);
          checkOutput($sformatf("sweep_%0d_%0d_rem_lt_div", a, b), int'(remainder) < b, 1);
        end
        start    = 1'b1;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom_range(15, 0));
        tick();
        start    = 1'b0;
        checkOutput($sformatf("sweep_%0d_%0d_done_cycle_start_ignored", a, b), {busy, done}, 0);
        checkOutput($sformatf("sweep_%0d_%0d_held", a, b), {div_by_zero, quotient, remainder}, {mdz[0], mq[WIDTH-1:0], mr[WIDTH-1:0]});
        for (int g = $urandom_range(3, 0); g > 0; g--) tick();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
